apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 102 ++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB requester: turns one command into a SETUP/ACCESS transfer and holds the
// response until it is consumed. Slow completers are aborted after TIMEOUT waits.
module apb_master #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic [1:0]        dbg_state
);

    // Handshakes: a command transfers on an edge with cmd_valid && cmd_ready, a
    // response on an edge with rsp_valid && rsp_ready; valid never waits on ready.
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE) && !reset;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr    <= cmd_addr;
                        pwrite   <= cmd_write;
                        pwdata   <= cmd_wdata;
                        wait_cnt <= '0;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over the timeout on the last permitted edge
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
